wb_riot: RTL and testbench



---
 rtl/wb_riot_pkg.sv | 28 ++
 rtl/riot_timer.sv | 78 +++++++
 rtl/wb_riot.sv | 85 ++++++++
 tb/tb_wb_riot.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/wb_riot_pkg.sv
// Shared constants and prescale helpers for the Wishbone RIOT peripheral.
package wb_riot_pkg;

   localparam logic [6:0] PORT_BASE    = 7'h00;
   localparam logic [6:0] INTIM        = 7'h04;
   localparam logic [6:0] TIMINT       = 7'h05;
   localparam logic [6:0] TIM_BASE     = 7'h14;
   localparam logic [6:0] TIM_IRQ_BASE = 7'h1C;

   localparam int PRESC_W = 10;

   typedef enum logic [1:0] {
      SEL_1T    = 2'd0,
      SEL_8T    = 2'd1,
      SEL_64T   = 2'd2,
      SEL_1024T = 2'd3
   } presc_sel_e;

   function automatic logic [10:0] div_of(presc_sel_e s);
      case (s)
         SEL_1T:  div_of = 11'd1;
         SEL_8T:  div_of = 11'd8;
         SEL_64T: div_of = 11'd64;
         default: div_of = 11'd1024;
      endcase
   endfunction

endpackage

// File: rtl/riot_timer.sv
// Interval timer: prescaler, down counter, underflow flag/mode and irq enable.
module riot_timer
   import wb_riot_pkg::*;
#(
   parameter int TIMER_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               tick,
   input  logic               load,
   input  presc_sel_e         load_sel,
   input  logic               load_irq,
   input  logic [7:0]         load_val,
   input  logic               rd_clr,
   output logic [TIMER_W-1:0] value,
   output logic               flag,
   output logic               irq
);

   logic [TIMER_W-1:0] timer_n;
   logic [PRESC_W-1:0] presc, presc_n;
   presc_sel_e         sel, sel_n;
   logic               flag_n, uf, uf_n, irq_en, irq_en_n;

   always_comb begin
      timer_n  = value;
      presc_n  = presc;
      sel_n    = sel;
      flag_n   = flag;
      uf_n     = uf;
      irq_en_n = irq_en;
      // A load discards any tick on the same edge.
      if (load) begin
         timer_n  = TIMER_W'(load_val);
         sel_n    = load_sel;
         presc_n  = '0;
         flag_n   = 1'b0;
         uf_n     = 1'b0;
         irq_en_n = load_irq;
      end else begin
         if (rd_clr) flag_n = 1'b0;
         // Underflow setting the flag overrides a same-edge read clear.
         if (tick) begin
            if (uf || ({1'b0, presc} == div_of(sel) - 11'd1)) begin
               presc_n = '0;
               timer_n = value - TIMER_W'(1);
               if (value == '0) begin
                  flag_n = 1'b1;
                  uf_n   = 1'b1;
               end
            end else begin
               presc_n = presc + PRESC_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value  <= '0;
         presc  <= '0;
         sel    <= SEL_1024T;
         flag   <= 1'b0;
         uf     <= 1'b0;
         irq_en <= 1'b0;
         irq    <= 1'b0;
      end else begin
         value  <= timer_n;
         presc  <= presc_n;
         sel    <= sel_n;
         flag   <= flag_n;
         uf     <= uf_n;
         irq_en <= irq_en_n;
         irq    <= flag_n & irq_en_n;
      end
   end

endmodule

// File: rtl/wb_riot.sv
// Wishbone RIOT: NUM_PORTS 8-bit I/O ports with DDRs plus the interval timer.
module wb_riot
   import wb_riot_pkg::*;
#(
   parameter int NUM_PORTS = 2,
   parameter int TIMER_W   = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   stb_i,
   input  logic                   we_i,
   input  logic [6:0]             adr_i,
   input  logic [7:0]             dat_i,
   output logic                   ack_o,
   output logic [7:0]             dat_o,
   input  logic                   tick_i,
   input  logic [8*NUM_PORTS-1:0] port_i,
   output logic [8*NUM_PORTS-1:0] port_o,
   output logic [8*NUM_PORTS-1:0] port_oe_o,
   output logic                   irq_o
);

   logic [NUM_PORTS-1:0][7:0] out_q, ddr_q, pin;
   logic [TIMER_W-1:0]        timer;
   logic                      accept, tim_addr, tim_wr, flag;
   logic [7:0]                rd_data;

   assign accept   = stb_i && !ack_o;
   // INTIM/TIMINT shadow port 2 when NUM_PORTS > 2; the timer wins.
   assign tim_addr = (adr_i == INTIM) || (adr_i == TIMINT);
   assign tim_wr   = accept && we_i &&
                     ((adr_i[6:2] == TIM_BASE[6:2]) || (adr_i[6:2] == TIM_IRQ_BASE[6:2]));
   assign pin      = port_i;
   assign port_o   = out_q;
   assign port_oe_o = ddr_q;

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            out_q[p] <= '0;
            ddr_q[p] <= '0;
         end else if (accept && we_i && !tim_addr) begin
            if (adr_i == PORT_BASE + 7'(2*p))     out_q[p] <= dat_i;
            if (adr_i == PORT_BASE + 7'(2*p + 1)) ddr_q[p] <= dat_i;
         end
      end
   end

   always_comb begin
      rd_data = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (adr_i == PORT_BASE + 7'(2*p))
            rd_data = (out_q[p] & ddr_q[p]) | (pin[p] & ~ddr_q[p]);
         if (adr_i == PORT_BASE + 7'(2*p + 1))
            rd_data = ddr_q[p];
      end
      if (adr_i == INTIM)  rd_data = timer[7:0];
      if (adr_i == TIMINT) rd_data = {flag, 7'b0};
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ack_o <= 1'b0;
         dat_o <= '0;
      end else begin
         ack_o <= accept;
         if (accept && !we_i) dat_o <= rd_data;
      end
   end

   riot_timer #(.TIMER_W(TIMER_W)) u_timer (
      .clk      (clk_i),
      .rst_n    (rst_ni),
      .tick     (tick_i),
      .load     (tim_wr),
      .load_sel (presc_sel_e'(adr_i[1:0])),
      .load_irq (adr_i[3]),
      .load_val (dat_i),
      .rd_clr   (accept && !we_i && (adr_i == INTIM)),
      .value    (timer),
      .flag     (flag),
      .irq      (irq_o)
   );

endmodule

// File: tb/tb_wb_riot.sv
// Directed bench for wb_riot: port vector table plus timer/bus corner sequences.
module tb_wb_riot;

   logic        clk_i = 0, rst_ni = 0;
   logic        stb_i = 0, we_i = 0, tick_i = 0;
   logic [6:0]  adr_i = '0;
   logic [7:0]  dat_i = '0;
   logic        ack_o, irq_o;
   logic [7:0]  dat_o;
   logic [15:0] port_i = '0, port_o, port_oe_o;

   logic        stb1 = 0, ack1, irq1;
   logic [7:0]  dat1, port_i1 = 8'hFF, port_o1, oe1;

   int checks = 0, errors = 0;

   always #5 clk_i = ~clk_i;

   wb_riot #(.NUM_PORTS(2), .TIMER_W(8)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .stb_i(stb_i), .we_i(we_i), .adr_i(adr_i),
      .dat_i(dat_i), .ack_o(ack_o), .dat_o(dat_o), .tick_i(tick_i), .port_i(port_i),
      .port_o(port_o), .port_oe_o(port_oe_o), .irq_o(irq_o));

   wb_riot #(.NUM_PORTS(1), .TIMER_W(8)) dut1 (
      .clk_i(clk_i), .rst_ni(rst_ni), .stb_i(stb1), .we_i(we_i), .adr_i(adr_i),
      .dat_i(dat_i), .ack_o(ack1), .dat_o(dat1), .tick_i(tick_i), .port_i(port_i1),
      .port_o(port_o1), .port_oe_o(oe1), .irq_o(irq1));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic bus(input logic w, input logic [6:0] a, input logic [7:0] d,
                      output logic [7:0] rd);
      @(negedge clk_i);
      stb_i = 1; we_i = w; adr_i = a; dat_i = d;
      @(negedge clk_i);
      stb_i = 0; we_i = 0;
      chk("ack", ack_o, 1'b1);
      rd = dat_o;
   endtask

   task automatic rd_chk(input string name, input logic [6:0] a, input logic [7:0] exp);
      logic [7:0] r;
      bus(1'b0, a, 8'h00, r);
      chk(name, r, exp);
   endtask

   task automatic wr(input logic [6:0] a, input logic [7:0] d);
      logic [7:0] r;
      bus(1'b1, a, d, r);
   endtask

   task automatic ticks(input int n);
      repeat (n) begin
         @(negedge clk_i); tick_i = 1;
         @(negedge clk_i); tick_i = 0;
      end
   endtask

   typedef struct {
      logic        we;
      logic [6:0]  adr;
      logic [7:0]  dat;
      logic [15:0] pin;
      logic [7:0]  exp_rd;
      logic [15:0] exp_out;
      logic [15:0] exp_oe;
   } vec_t;

   vec_t vecs[12];

   initial begin
      logic [7:0] r;
      vecs[0]  = '{0, 7'h00, 8'h00, 16'h00A5, 8'hA5, 16'h0000, 16'h0000};
      vecs[1]  = '{1, 7'h01, 8'hF0, 16'h000F, 8'h00, 16'h0000, 16'h00F0};
      vecs[2]  = '{1, 7'h00, 8'h3C, 16'h000F, 8'h00, 16'h003C, 16'h00F0};
      vecs[3]  = '{0, 7'h00, 8'h00, 16'h000F, 8'h3F, 16'h003C, 16'h00F0};
      vecs[4]  = '{1, 7'h03, 8'h0F, 16'h550F, 8'h00, 16'h003C, 16'h0FF0};
      vecs[5]  = '{1, 7'h02, 8'hAA, 16'h550F, 8'h00, 16'hAA3C, 16'h0FF0};
      vecs[6]  = '{0, 7'h02, 8'h00, 16'h550F, 8'h5A, 16'hAA3C, 16'h0FF0};
      vecs[7]  = '{0, 7'h03, 8'h00, 16'h550F, 8'h0F, 16'hAA3C, 16'h0FF0};
      vecs[8]  = '{0, 7'h01, 8'h00, 16'h550F, 8'hF0, 16'hAA3C, 16'h0FF0};
      vecs[9]  = '{1, 7'h10, 8'h77, 16'h550F, 8'h00, 16'hAA3C, 16'h0FF0};
      vecs[10] = '{0, 7'h10, 8'h00, 16'h550F, 8'h00, 16'hAA3C, 16'h0FF0};
      vecs[11] = '{0, 7'h05, 8'h00, 16'h550F, 8'h00, 16'hAA3C, 16'h0FF0};

      port_i = 16'h00A5;
      repeat (2) @(negedge clk_i);
      chk("rst_ack", ack_o, 1'b0);
      chk("rst_dat", dat_o, 8'h00);
      chk("rst_oe", port_oe_o, 16'h0000);
      chk("rst_irq", irq_o, 1'b0);
      rst_ni = 1;

      for (int i = 0; i < 12; i++) begin
         port_i = vecs[i].pin;
         bus(vecs[i].we, vecs[i].adr, vecs[i].dat, r);
         if (!vecs[i].we) chk($sformatf("vec%0d_rd", i), r, vecs[i].exp_rd);
         chk($sformatf("vec%0d_out", i), port_o, vecs[i].exp_out);
         chk($sformatf("vec%0d_oe", i), port_oe_o, vecs[i].exp_oe);
      end
      rd_chk("intim_idle", 7'h04, 8'h00);

      // divide by 1, N=2: underflow on tick 3, then decrement every tick
      wr(7'h14, 8'h02);
      ticks(2);
      rd_chk("tim1_pre", 7'h05, 8'h00);
      ticks(1);
      rd_chk("tim1_flag", 7'h05, 8'h80);
      chk("tim1_noirq", irq_o, 1'b0);
      ticks(1);
      rd_chk("tim1_fe", 7'h04, 8'hFE);
      rd_chk("tim1_clr", 7'h05, 8'h00);

      // divide by 8 with irq, N=1: irq after tick 16
      wr(7'h1D, 8'h01);
      ticks(15);
      chk("irq8_early", irq_o, 1'b0);
      ticks(1);
      chk("irq8_rise", irq_o, 1'b1);
      wr(7'h15, 8'h00);
      chk("irq8_drop", irq_o, 1'b0);
      ticks(7);
      rd_chk("div8_pre", 7'h05, 8'h00);
      ticks(1);
      rd_chk("div8_flag", 7'h05, 8'h80);
      chk("div8_noirq", irq_o, 1'b0);

      // timer write colliding with tick: tick discarded, 64 ticks to underflow
      @(negedge clk_i);
      stb_i = 1; we_i = 1; adr_i = 7'h16; dat_i = 8'h00; tick_i = 1;
      @(negedge clk_i);
      stb_i = 0; we_i = 0; tick_i = 0;
      ticks(63);
      rd_chk("div64_pre", 7'h05, 8'h00);
      ticks(1);
      rd_chk("div64_flag", 7'h05, 8'h80);

      // INTIM read on the underflow edge: flag stays set
      wr(7'h14, 8'h00);
      @(negedge clk_i);
      stb_i = 1; we_i = 0; adr_i = 7'h04; tick_i = 1;
      @(negedge clk_i);
      stb_i = 0; tick_i = 0;
      chk("rdul_dat", dat_o, 8'h00);
      rd_chk("rdul_flag", 7'h05, 8'h80);

      // reset mid-operation, then default 1024 divider
      wr(7'h1C, 8'h05);
      @(negedge clk_i);
      rst_ni = 0;
      #1;
      chk("mrst_out", port_o, 16'h0000);
      chk("mrst_oe", port_oe_o, 16'h0000);
      chk("mrst_dat", dat_o, 8'h00);
      @(negedge clk_i);
      rst_ni = 1;
      rd_chk("mrst_tim", 7'h04, 8'h00);
      ticks(1023);
      rd_chk("d1024_pre", 7'h05, 8'h00);
      ticks(1);
      rd_chk("d1024_flag", 7'h05, 8'h80);
      rd_chk("d1024_val", 7'h04, 8'hFF);

      // NUM_PORTS=1: absent port reads zero; back-to-back strobes ack 1,0,1
      @(negedge clk_i);
      stb1 = 1; we_i = 0; adr_i = 7'h02;
      @(negedge clk_i);
      chk("np1_ack0", ack1, 1'b1);
      chk("np1_dat", dat1, 8'h00);
      @(negedge clk_i);
      chk("np1_ack1", ack1, 1'b0);
      @(negedge clk_i);
      chk("np1_ack2", ack1, 1'b1);
      stb1 = 0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
